// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types, constants and the byte-merge helper for the dmem arbiter
package dmem_arb_pkg;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam int CORE = 0;
    localparam int DBG  = 1;
    localparam int BE_W = 4;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0]     old_w,
        input logic [31:0]     new_w,
        input logic [BE_W-1:0] be
    );
        logic [31:0] res;
        for (int k = 0; k < BE_W; k++)
            res[8*k +: 8] = be[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
        return res;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker; a lone requester wins, a tie goes to the port not granted last
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant,
    output logic       grant_valid
);

    assign grant       = (&valid) ? ~last_grant : valid[1];
    assign grant_valid = |valid;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter sequencing accesses onto a single-port word memory
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               req_valid,
    output logic [1:0]               req_ready,
    input  logic [1:0]               req_we,
    input  logic [1:0][AW-1:0]       req_addr,
    input  logic [1:0][DW-1:0]       req_wdata,
    input  logic [1:0][BE_W-1:0]     req_be,
    output logic [1:0]               rsp_valid,
    output logic [DW-1:0]            rsp_rdata,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_a,
    output logic [DW-1:0]            mem_wd,
    input  logic [DW-1:0]            mem_rd
);

    state_t          state, state_n;
    logic            last_grant;
    logic            grant, grant_valid;
    logic            owner_q, we_q;
    logic [DW-1:0]   wdata_q, rdata_q;
    logic [BE_W-1:0] be_q;
    logic            addr_lsb_unused;

    // accesses are word-aligned, so the byte offset bits are dropped
    assign addr_lsb_unused = ^{req_addr[0][1:0], req_addr[1][1:0]};

    rr_arb2 u_pick (
        .valid       (req_valid),
        .last_grant  (last_grant),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // next state plus all per-state outputs; memory strobes only ever come from EXEC
    always_comb begin
        state_n   = state;
        req_ready = '0;
        mem_we    = 1'b0;
        mem_wd    = '0;
        rsp_valid = '0;
        rsp_rdata = '0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    req_ready[grant] = 1'b1;
                    state_n          = EXEC;
                end
            end
            EXEC: begin
                mem_we  = we_q && (be_q != '0);
                mem_wd  = we_q ? merge_bytes(mem_rd, wdata_q, be_q) : '0;
                state_n = RESP;
            end
            RESP: begin
                rsp_valid[owner_q] = 1'b1;
                rsp_rdata          = we_q ? '0 : rdata_q;
                state_n            = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // state, grant history, captured request and the held memory address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            be_q       <= '0;
            rdata_q    <= '0;
            mem_a      <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && grant_valid) begin
                owner_q    <= grant;
                last_grant <= grant;
                we_q       <= req_we[grant];
                wdata_q    <= req_wdata[grant];
                be_q       <= req_be[grant];
                mem_a      <= {req_addr[grant][AW-1:2], 2'b00};
            end
            if (state == EXEC)
                rdata_q <= mem_rd;
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and access sequencer in front of the single-port data memory (dmem: clk, we, a, wd, rd; word write on posedge, combinational read).
- Port 0 is the core load/store unit; port 1 is the debug/loader requester.
- Each access is accepted by valid/ready handshake, executed on dmem in a dedicated cycle, and acknowledged with a one-cycle response pulse.
- Byte-enabled stores are built as read-merge-write, because dmem only writes whole words.

Parameters:
AW, 32, address width in bits
DW, 32, data width in bits; fixed at 32 (byte enables are DW/8 = 4)

Ports:
clk  in  1  system clock; all state updates on posedge
rst_n  in  1  reset; one clock, asynchronous assert, active-low (already decided)
req_valid  in  2  per-requester request valid; bit 0 = core, bit 1 = debug
req_ready  out  2  per-requester accept; at most one bit high
req_we  in  2  per-requester write (1) / read (0)
req_addr  in  2xAW  per-requester byte address
req_wdata  in  2xDW  per-requester write data
req_be  in  2x4  per-requester byte enables; writes only
rsp_valid  out  2  one-cycle response pulse to the owning requester
rsp_rdata  out  DW  read data; valid only while a rsp_valid bit is high
mem_we  out  1  to dmem.we
mem_a  out  AW  to dmem.a
mem_wd  out  DW  to dmem.wd
mem_rd  in  DW  from dmem.rd

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, mem_we=0, mem_a=0, mem_wd=0, last_grant=1 (so port 0 wins first).
- IDLE:
  - req_ready[g]=1 combinationally for the granted port g, only while req_valid[g]=1.
  - Grant rule: only one port valid → that port. Both valid → the port not equal to last_grant (round-robin).
  - On handshake, capture owner g, we, addr, wdata and be into registers; set last_grant=g; go to EXEC.
  - No valid request → stay in IDLE.
- EXEC:
  - mem_a = {addr_q[AW-1:2], 2'b00}; addr[1:0] are ignored (word-aligned access).
  - Read: capture mem_rd into rdata_q; mem_we=0.
  - Write: mem_wd = per-byte merge (byte k = be_q[k] ? wdata_q byte k : mem_rd byte k); mem_we=1 iff be_q!=0.
  - Write with be=0000: no memory write, but a response is still issued.
  - Always go to RESP.
- RESP:
  - rsp_valid[owner]=1 for exactly one cycle; rsp_rdata = rdata_q for reads, 0 for writes.
  - mem_we=0; go to IDLE.
- Timing and throughput:
  - Latency: handshake at cycle N, memory write at posedge N+2, rsp_valid during cycle N+2.
  - Maximum throughput is one access per 3 cycles.
- mem_we is asserted only in EXEC. mem_a holds its last value outside EXEC.
- Responses have no backpressure; the requester must sample rsp_valid.
- Requests must hold stable while valid && !ready. A port dropping valid before ready is not an error; it is simply not granted.
- Fairness: with both ports continuously valid, grants alternate 0,1,0,1 and neither waits more than one transaction.
- Reset mid-operation: asynchronous return to IDLE; mem_we drops immediately; the in-flight access gets no response; last_grant returns to 1.

Decomposition:
- Package dmem_arb_pkg:
  - state enum {IDLE, EXEC, RESP}
  - requester index constants CORE=0, DBG=1
  - BE_W=4
  - function merge_bytes(old, new, be)
- One natural sub-module: rr_arb2, a 2-way round-robin picker (inputs valid[1:0] and last_grant; outputs grant index and grant-valid). All other logic is flat in dmem_arbiter.

Test Plan:
- Read: after reset, port 0 reads addr 0x10 holding 0xDEADBEEF → ready[0] in cycle 0, mem_a=0x10 in cycle 1, rsp_valid[0]=1 with rsp_rdata=0xDEADBEEF in cycle 2.
- Full write then read: port 1 writes 0x12345678 to 0x20 with be=1111, then reads 0x20 → mem_we high exactly one cycle; readback 0x12345678 on rsp_valid[1].
- Partial write: word at 0x24 = 0xAABBCCDD; port 0 writes 0x11223344 with be=0101 → readback 0xAA22CC44.
- Contention: both ports valid continuously for 4 requests each → grant order 0,1,0,1,... and rsp_valid bits alternate; ready never has both bits high.
- Edge cases:
  - be=0000 write to 0x30 → mem_we stays 0 and a response is still issued.
  - Unaligned address 0x33 → mem_a=0x30.
- Reset during EXEC of a write → mem_we low immediately, no rsp_valid; after release, port 0 wins the first contended grant.
